// File: rtl/gbuf_c_reader_pkg.sv
// Shared definitions for the global_buffer_C drain reader.
//   - default widths for buffer index, buffer entry and response beat
//   - FSM state encoding
//   - lane counter width helper
package gbuf_c_reader_pkg;

  localparam int unsigned ADDR_BITS_DEF = 16;
  localparam int unsigned DATA_BITS_DEF = 128;
  localparam int unsigned OUT_BITS_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  // Width of a counter that indexes 'lanes' lanes (at least one bit).
  function automatic int unsigned lane_bits(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/gbuf_c_reader_if.sv
// Bundle of the drain reader's command, buffer-read and response signals.
//   master : the reader (drives rd_en/rd_index, rsp_valid/rsp_data, busy/done)
//   slave  : the environment (drives start/abort/base_addr/num_words,
//            rd_data, rsp_ready)
interface gbuf_c_reader_if
  import gbuf_c_reader_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned OUT_BITS  = OUT_BITS_DEF
);

  logic                 start;
  logic                 abort;
  logic [ADDR_BITS-1:0] base_addr;
  logic [ADDR_BITS-1:0] num_words;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_index;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_BITS-1:0]  rsp_data;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, abort, base_addr, num_words, rd_data, rsp_ready,
    output rd_en, rd_index, rsp_valid, rsp_data, busy, done
  );

  modport slave (
    output start, abort, base_addr, num_words, rd_data, rsp_ready,
    input  rd_en, rd_index, rsp_valid, rsp_data, busy, done
  );

endinterface

// File: rtl/gbuf_lane_serializer.sv
// Holds one buffer entry and presents it as LANES beats, lane 0 first.
//   clk, rst_n : clock, async active-low reset
//   load       : capture load_data into the entry register, restart at lane 0
//   load_data  : buffer entry to serialize
//   advance    : current beat was accepted, move to the next lane
//   out_data   : registered current beat
//   last_c     : current lane is the final lane of the entry
module gbuf_lane_serializer
  import gbuf_c_reader_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned OUT_BITS  = OUT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 advance,
  output logic [OUT_BITS-1:0]  out_data,
  output logic                 last_c
);

  localparam int unsigned LANES     = DATA_BITS / OUT_BITS;
  localparam int unsigned LANE_BITS = lane_bits(LANES);

  logic [DATA_BITS-1:0] entry_q;
  logic [LANE_BITS-1:0] lane_q;
  logic [LANE_BITS-1:0] lane_inc;
  logic [OUT_BITS-1:0]  lane_word [LANES];

  // Split the entry register into beat-sized lanes.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_word[g] = entry_q[g*OUT_BITS +: OUT_BITS];
  end

  // Next lane wraps explicitly so non-power-of-two lane counts work.
  always_comb begin
    last_c   = (lane_q == LANE_BITS'(LANES - 1));
    lane_inc = last_c ? '0 : lane_q + LANE_BITS'(1);
  end

  // out_data is preloaded with the next lane so the beat is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q  <= '0;
      lane_q   <= '0;
      out_data <= '0;
    end else if (load) begin
      entry_q  <= load_data;
      lane_q   <= '0;
      out_data <= load_data[OUT_BITS-1:0];
    end else if (advance) begin
      lane_q   <= lane_inc;
      out_data <= lane_word[lane_inc];
    end
  end

endmodule

// File: rtl/gbuf_c_reader.sv
// Drains a range of global_buffer_C entries and streams each entry out as
// LANES response beats over a valid/ready handshake.
//   clk, rst_n : clock, async active-low reset
//   bus        : gbuf_c_reader_if.master
//                start/base_addr/num_words launch a drain, abort cancels it,
//                rd_en/rd_index/rd_data form the buffer read port,
//                rsp_valid/rsp_ready/rsp_data form the beat stream,
//                busy marks a drain in progress, done pulses at the end.
module gbuf_c_reader
  import gbuf_c_reader_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF,
  parameter int unsigned OUT_BITS  = OUT_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  gbuf_c_reader_if.master bus
);

  state_e               state_q;
  state_e               state_nxt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [ADDR_BITS-1:0] remain_q;
  logic [ADDR_BITS-1:0] remain_nxt;
  logic                 load_c;
  logic                 beat_c;
  logic                 last_c;

  logic                 rd_en_q;
  logic [ADDR_BITS-1:0] rd_index_q;
  logic                 rsp_valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic [OUT_BITS-1:0]  ser_data;

  gbuf_lane_serializer #(
    .DATA_BITS (DATA_BITS),
    .OUT_BITS  (OUT_BITS)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .load_data (bus.rd_data),
    .advance   (beat_c),
    .out_data  (ser_data),
    .last_c    (last_c)
  );

  // Next-state, counter update and serializer control.
  always_comb begin
    state_nxt  = state_q;
    addr_nxt   = addr_q;
    remain_nxt = remain_q;
    load_c     = 1'b0;
    beat_c     = 1'b0;

    // Abort wins over any same-cycle beat transfer.
    if ((state_q != ST_IDLE) && bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            addr_nxt   = bus.base_addr;
            remain_nxt = bus.num_words;
            state_nxt  = (bus.num_words == '0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_nxt = ST_CAPTURE;
        end
        // Buffer data registered on the falling edge of FETCH is stable here.
        ST_CAPTURE: begin
          load_c    = 1'b1;
          state_nxt = ST_SEND;
        end
        ST_SEND: begin
          if (bus.rsp_ready) begin
            beat_c = 1'b1;
            if (last_c) begin
              addr_nxt   = addr_q + ADDR_BITS'(1);
              remain_nxt = remain_q - ADDR_BITS'(1);
              state_nxt  = (remain_q == ADDR_BITS'(1)) ? ST_FINISH : ST_FETCH;
            end
          end
        end
        ST_FINISH: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_nxt;
      addr_q   <= addr_nxt;
      remain_q <= remain_nxt;
    end
  end

  // Outputs decoded from the next state so they line up with the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q     <= 1'b0;
      rd_index_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_en_q     <= (state_nxt == ST_FETCH);
      rsp_valid_q <= (state_nxt == ST_SEND);
      busy_q      <= (state_nxt != ST_IDLE);
      done_q      <= (state_nxt == ST_FINISH);
      if (state_nxt == ST_FETCH) begin
        rd_index_q <= addr_nxt;
      end
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_index  = rd_index_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = ser_data;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_gbuf_c_reader.sv
// Directed bench for gbuf_c_reader: a buffer model answers reads on the
// falling edge, expected indices/beats are queued when a drain is launched
// and matched against what a negedge monitor observes.
module tb_gbuf_c_reader;
  import gbuf_c_reader_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 128;
  localparam int unsigned OW    = 32;
  localparam int unsigned LANES = DW / OW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gbuf_c_reader_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .OUT_BITS(OW)) bus ();

  gbuf_c_reader #(.ADDR_BITS(AW), .DATA_BITS(DW), .OUT_BITS(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:65535];

  // Buffer model: registers data_out on the falling edge of a read.
  always @(negedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_index];
  end

  logic [OW-1:0] obs_beats [$];
  logic [AW-1:0] obs_idx   [$];
  logic [OW-1:0] stall_now [$];
  logic [OW-1:0] stall_held[$];
  logic [OW-1:0] exp_beats [$];
  logic [AW-1:0] exp_idx   [$];
  int            done_cnt   = 0;
  logic          hold_valid = 1'b0;
  logic [OW-1:0] hold_data  = '0;
  int            n_checks   = 0;
  int            n_fail     = 0;
  bit            pat [4]    = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Monitor: transfers, reads, done pulses and data held across stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid && bus.rsp_ready && !bus.abort) obs_beats.push_back(bus.rsp_data);
      if (bus.rd_en) obs_idx.push_back(bus.rd_index);
      if (bus.done) done_cnt = done_cnt + 1;
      if (hold_valid && bus.rsp_valid) begin
        stall_now.push_back(bus.rsp_data);
        stall_held.push_back(hold_data);
      end
      hold_valid = bus.rsp_valid && !bus.rsp_ready;
      hold_data  = bus.rsp_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_beats.delete();
    obs_idx.delete();
    stall_now.delete();
    stall_held.delete();
  endtask

  task automatic expect_words(input logic [AW-1:0] base, input int num);
    logic [AW-1:0] idx;
    logic [DW-1:0] ent;
    for (int w = 0; w < num; w++) begin
      idx = base + AW'(w);
      ent = mem[idx];
      exp_idx.push_back(idx);
      for (int l = 0; l < int'(LANES); l++) exp_beats.push_back(ent[l*OW +: OW]);
    end
  endtask

  task automatic compare_streams(input string tag);
    logic [AW-1:0] ei, oi;
    logic [OW-1:0] eb, ob;
    while (exp_idx.size() > 0) begin
      ei = exp_idx.pop_front();
      if (obs_idx.size() > 0) oi = obs_idx.pop_front(); else oi = 'x;
      chk({tag, "_rd_index"}, DW'(oi), DW'(ei));
    end
    chk({tag, "_extra_reads"}, DW'(obs_idx.size()), DW'(0));
    while (exp_beats.size() > 0) begin
      eb = exp_beats.pop_front();
      if (obs_beats.size() > 0) ob = obs_beats.pop_front(); else ob = 'x;
      chk({tag, "_beat"}, DW'(ob), DW'(eb));
    end
    chk({tag, "_extra_beats"}, DW'(obs_beats.size()), DW'(0));
    while (stall_now.size() > 0) begin
      ob = stall_now.pop_front();
      eb = stall_held.pop_front();
      chk({tag, "_stall_hold"}, DW'(ob), DW'(eb));
    end
  endtask

  // Launch a drain and wait for done; exp_cycles < 0 skips the latency check.
  task automatic run_drain(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] num,
                           input bit stall, input bit poke, input int exp_cycles);
    int d0;
    int cycles;
    d0     = done_cnt;
    cycles = 0;
    clear_obs();
    expect_words(base, int'(num));
    bus.base_addr = base;
    bus.num_words = num;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && cycles < 400) begin
      bus.rsp_ready = stall ? pat[cycles % 4] : 1'b1;
      bus.start     = poke && (cycles == 3);
      tick();
      cycles++;
    end
    bus.start     = 1'b0;
    bus.rsp_ready = 1'b1;
    chk({tag, "_done_seen"}, DW'(bus.done), DW'(1));
    if (exp_cycles >= 0) chk({tag, "_cycles"}, DW'(cycles), DW'(exp_cycles));
    tick();
    chk({tag, "_done_width"}, DW'(bus.done), DW'(0));
    chk({tag, "_busy_idle"}, DW'(bus.busy), DW'(0));
    tick();
    chk({tag, "_done_count"}, DW'(done_cnt - d0), DW'(1));
    if (stall) chk({tag, "_stalls_seen"}, DW'(stall_now.size() > 0), DW'(1));
    compare_streams(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},     DW'(bus.rd_en),     DW'(0));
    chk({tag, "_rd_index"},  DW'(bus.rd_index),  DW'(0));
    chk({tag, "_rsp_valid"}, DW'(bus.rsp_valid), DW'(0));
    chk({tag, "_rsp_data"},  DW'(bus.rsp_data),  DW'(0));
    chk({tag, "_busy"},      DW'(bus.busy),      DW'(0));
    chk({tag, "_done"},      DW'(bus.done),      DW'(0));
  endtask

  initial begin
    int d0;
    int k;
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.rsp_ready = 1'b1;

    mem[16'h0010] = 128'h44444444_33333333_22222222_11111111;
    mem[16'h0020] = 128'hA0000004_A0000003_A0000002_A0000001;
    mem[16'h0021] = 128'hB1B1B1B4_B1B1B1B3_B1B1B1B2_B1B1B1B1;
    mem[16'h0022] = 128'hC2C2C2C4_C2C2C2C3_C2C2C2C2_C2C2C2C1;
    mem[16'hFFFF] = 128'hFFFF0004_FFFF0003_FFFF0002_FFFF0001;
    mem[16'h0000] = 128'h00000D04_00000D03_00000D02_00000D01;

    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_drain("single", 16'h0010, 16'd1, 1'b0, 1'b0, 6);
    run_drain("triple", 16'h0020, 16'd3, 1'b0, 1'b1, 18);
    run_drain("empty",  16'h0030, 16'd0, 1'b0, 1'b0, 0);
    run_drain("stall",  16'h0021, 16'd2, 1'b1, 1'b0, -1);
    run_drain("wrap",   16'hFFFF, 16'd2, 1'b0, 1'b0, 12);

    // Abort after the second beat of a two-word drain.
    clear_obs();
    d0 = done_cnt;
    exp_idx.push_back(16'h0020);
    exp_beats.push_back(32'hA0000001);
    exp_beats.push_back(32'hA0000002);
    bus.base_addr = 16'h0020;
    bus.num_words = 16'd2;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (obs_beats.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    chk("abort_reached_beat2", DW'(obs_beats.size() >= 2), DW'(1));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", DW'(bus.busy), DW'(0));
    chk("abort_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    repeat (8) tick();
    chk("abort_no_done", DW'(done_cnt - d0), DW'(0));
    compare_streams("abort");
    run_drain("after_abort", 16'h0010, 16'd1, 1'b0, 1'b0, 6);

    // Reset in the middle of SEND.
    clear_obs();
    bus.base_addr = 16'h0010;
    bus.num_words = 16'd1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    while (bus.rsp_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    tick();
    chk("pre_reset_in_send", DW'(bus.rsp_valid), DW'(1));
    rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    d0 = done_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_reset_busy", DW'(bus.busy), DW'(0));
    chk("post_reset_no_done", DW'(done_cnt - d0), DW'(0));
    clear_obs();
    run_drain("after_reset", 16'h0022, 16'd1, 1'b0, 1'b0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
